// File: rtl/cordic_lut_loader_if.sv
// cordic_lut_loader_if: word-stream input and LUT write-port bundle of the CORDIC table loader
interface cordic_lut_loader_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 48,
   parameter int IN_W   = 16
);
   logic              start;
   logic [IN_W-1:0]   in_data;
   logic              in_valid;
   logic              in_ready;
   logic              lut_wen;
   logic [ADDR_W-1:0] lut_index;
   logic [DATA_W-1:0] lut_data;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   modport master (
      input  start, in_data, in_valid,
      output in_ready, lut_wen, lut_index, lut_data, core_rst_n, busy, done
   );
   modport slave (
      output start, in_data, in_valid,
      input  in_ready, lut_wen, lut_index, lut_data, core_rst_n, busy, done
   );
endinterface

// File: rtl/cordic_lut_loader.sv
// cordic_lut_loader: packs a word stream into LUT entries and writes the whole CORDIC table with the core held in reset
module cordic_lut_loader #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 48,
   parameter int IN_W       = 16,
   parameter int RST_CYCLES = 2
) (
   input logic                 clk,
   input logic                 reset,
   cordic_lut_loader_if.master lut_if
);
   localparam int WPE = DATA_W / IN_W;
   localparam int WW  = WPE > 1 ? $clog2(WPE) : 1;
   localparam int RW  = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, FILL, WRITE, RELEASE} state_t;
   state_t            state_q, state_d;
   logic [WW-1:0]     word_cnt_q, word_cnt_d;
   logic [ADDR_W-1:0] entry_cnt_q, entry_cnt_d;
   logic [RW-1:0]     rel_cnt_q, rel_cnt_d;
   logic [DATA_W-1:0] asm_q, asm_d;
   logic [ADDR_W-1:0] lut_index_q, lut_index_d;
   logic [DATA_W-1:0] lut_data_q, lut_data_d;
   logic              in_ready_q, lut_wen_q, core_rst_n_q, busy_q, done_q;
   logic              accept, last_word;
   logic [DATA_W-1:0] shifted;
   assign accept    = lut_if.in_valid & in_ready_q;
   assign last_word = word_cnt_q == WW'(WPE - 1);
   // first word of an entry ends up in the most significant slot
   assign shifted   = (asm_q << IN_W) | DATA_W'(lut_if.in_data);
   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      entry_cnt_d = entry_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      asm_d       = asm_q;
      lut_index_d = lut_index_q;
      lut_data_d  = lut_data_q;
      case (state_q)
         IDLE: if (lut_if.start) begin
            state_d     = FILL;
            word_cnt_d  = '0;
            entry_cnt_d = '0;
         end
         FILL: if (accept) begin
            asm_d      = shifted;
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
            if (last_word) begin
               state_d     = WRITE;
               lut_index_d = entry_cnt_q;
               lut_data_d  = shifted;
            end
         end
         WRITE: begin
            state_d     = entry_cnt_q == '1 ? RELEASE : FILL;
            entry_cnt_d = entry_cnt_q == '1 ? entry_cnt_q : entry_cnt_q + 1'b1;
            rel_cnt_d   = '0;
         end
         RELEASE: begin
            rel_cnt_d = rel_cnt_q + 1'b1;
            state_d   = rel_cnt_q == RW'(RST_CYCLES - 1) ? IDLE : RELEASE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         word_cnt_q   <= '0;
         entry_cnt_q  <= '0;
         rel_cnt_q    <= '0;
         asm_q        <= '0;
         lut_index_q  <= '0;
         lut_data_q   <= '0;
         in_ready_q   <= 1'b0;
         lut_wen_q    <= 1'b1;
         core_rst_n_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         entry_cnt_q  <= entry_cnt_d;
         rel_cnt_q    <= rel_cnt_d;
         asm_q        <= asm_d;
         lut_index_q  <= lut_index_d;
         lut_data_q   <= lut_data_d;
         in_ready_q   <= state_d == FILL;
         lut_wen_q    <= state_d != WRITE;
         core_rst_n_q <= state_d == IDLE;
         busy_q       <= state_d != IDLE;
         done_q       <= state_q == RELEASE && state_d == IDLE;
      end
   end
   assign lut_if.in_ready   = in_ready_q;
   assign lut_if.lut_wen    = lut_wen_q;
   assign lut_if.lut_index  = lut_index_q;
   assign lut_if.lut_data   = lut_data_q;
   assign lut_if.core_rst_n = core_rst_n_q;
   assign lut_if.busy       = busy_q;
   assign lut_if.done       = done_q;
endmodule
